// File: rtl/rs_pkg.sv
// Shared types for the reservation-station bank: entry lifecycle states and
// the default-width entry record.
package rs_pkg;

    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2,
        RS_EXEC  = 2'd3
    } rs_state_e;

    // A producer tag of zero means the operand value is already present.
    localparam int TAG_NONE = 0;

    localparam int RS_DATA_W = 16;
    localparam int RS_TAG_W  = 3;
    localparam int RS_OP_W   = 3;
    localparam int RS_REG_W  = 3;

    typedef struct packed {
        rs_state_e             state;
        logic [RS_OP_W-1:0]    op;
        logic [RS_REG_W-1:0]   rd;
        logic [RS_DATA_W-1:0]  vj;
        logic [RS_DATA_W-1:0]  vk;
        logic [RS_TAG_W-1:0]   qj;
        logic [RS_TAG_W-1:0]   qk;
    } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station entry: lifecycle state, instruction capture with
// issue-time CDB bypass, and CDB snooping for outstanding operands.
module rs_entry
    import rs_pkg::*;
#(
    parameter int DATA_W = RS_DATA_W,
    parameter int TAG_W  = RS_TAG_W,
    parameter int OP_W   = RS_OP_W,
    parameter int REG_W  = RS_REG_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              alloc,
    input  logic              dispatch,
    input  logic              complete,
    input  logic [OP_W-1:0]   issue_op,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [TAG_W-1:0]  issue_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              is_free,
    output logic              is_ready,
    output logic              is_exec,
    output logic [OP_W-1:0]   op,
    output logic [REG_W-1:0]  rd,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);

    localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

    rs_state_e         state, state_nxt;
    logic [TAG_W-1:0]  qj, qk, src_qj, src_qk, qj_nxt, qk_nxt;
    logic [DATA_W-1:0] src_vj, src_vk, vj_nxt, vk_nxt;
    logic              loading, capture, hit_j, hit_k, operands_ok;

    // The same snoop path serves the freshly issued operands and the held ones.
    always_comb begin
        loading     = alloc && (state == RS_FREE);
        capture     = loading || (state == RS_WAIT) || (state == RS_READY);
        src_qj      = loading ? issue_qj : qj;
        src_qk      = loading ? issue_qk : qk;
        src_vj      = loading ? issue_vj : vj;
        src_vk      = loading ? issue_vk : vk;
        hit_j       = cdb_valid && (src_qj != NO_TAG) && (src_qj == cdb_tag);
        hit_k       = cdb_valid && (src_qk != NO_TAG) && (src_qk == cdb_tag);
        qj_nxt      = hit_j ? NO_TAG : src_qj;
        qk_nxt      = hit_k ? NO_TAG : src_qk;
        vj_nxt      = hit_j ? cdb_value : src_vj;
        vk_nxt      = hit_k ? cdb_value : src_vk;
        operands_ok = (qj_nxt == NO_TAG) && (qk_nxt == NO_TAG);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RS_FREE:  if (loading)     state_nxt = operands_ok ? RS_READY : RS_WAIT;
            RS_WAIT:  if (operands_ok) state_nxt = RS_READY;
            RS_READY: if (dispatch)    state_nxt = RS_EXEC;
            RS_EXEC:  if (complete)    state_nxt = RS_FREE;
            default:                   state_nxt = RS_FREE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= RS_FREE;
            qj    <= NO_TAG;
            qk    <= NO_TAG;
        end else begin
            state <= state_nxt;
            if (capture) begin
                qj <= qj_nxt;
                qk <= qk_nxt;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (loading) begin
            op <= issue_op;
            rd <= issue_rd;
        end
        if (capture) begin
            vj <= vj_nxt;
            vk <= vk_nxt;
        end
    end

    assign is_free  = (state == RS_FREE);
    assign is_ready = (state == RS_READY);
    assign is_exec  = (state == RS_EXEC);

endmodule

// File: rtl/res_station_bank.sv
// Multi-entry reservation-station bank sharing one functional unit: lowest-index
// allocation and dispatch, Done matching and the register-file write enable.
module res_station_bank
    import rs_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 3,
    parameter int OP_W     = 3,
    parameter int REG_W    = 3,
    parameter int DEPTH    = 2,
    parameter int TAG_BASE = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Issue_valid,
    output logic              Issue_ready,
    input  logic [OP_W-1:0]   Issue_op,
    input  logic [REG_W-1:0]  Issue_rd,
    input  logic [DATA_W-1:0] Vj,
    input  logic [DATA_W-1:0] Vk,
    input  logic [TAG_W-1:0]  Qj,
    input  logic [TAG_W-1:0]  Qk,
    output logic [TAG_W-1:0]  Issue_tag,
    input  logic              Cdb_valid,
    input  logic [TAG_W-1:0]  Cdb_tag,
    input  logic [DATA_W-1:0] Cdb_value,
    output logic              Exec_valid,
    input  logic              Exec_ready,
    output logic [OP_W-1:0]   Exec_op,
    output logic [DATA_W-1:0] Exec_vj,
    output logic [DATA_W-1:0] Exec_vk,
    output logic [TAG_W-1:0]  Exec_tag,
    input  logic              Done,
    input  logic [TAG_W-1:0]  Done_tag,
    output logic              R_enable,
    output logic [REG_W-1:0]  R_target,
    output logic [DEPTH-1:0]  Busy
);

    logic [DEPTH-1:0]  free_m, ready_m, exec_m, alloc_v, disp_v, comp_v;
    logic [OP_W-1:0]   e_op [DEPTH];
    logic [REG_W-1:0]  e_rd [DEPTH];
    logic [DATA_W-1:0] e_vj [DEPTH];
    logic [DATA_W-1:0] e_vk [DEPTH];
    logic [TAG_W-1:0]  tag_of [DEPTH];
    logic [REG_W-1:0]  done_rd;
    logic              alloc_found, disp_found;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign tag_of[g] = TAG_W'(TAG_BASE + g);

        rs_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W),
            .OP_W   (OP_W),
            .REG_W  (REG_W)
        ) u_entry (
            .Clock     (Clock),
            .Reset     (Reset),
            .alloc     (alloc_v[g]),
            .dispatch  (disp_v[g]),
            .complete  (comp_v[g]),
            .issue_op  (Issue_op),
            .issue_rd  (Issue_rd),
            .issue_vj  (Vj),
            .issue_vk  (Vk),
            .issue_qj  (Qj),
            .issue_qk  (Qk),
            .cdb_valid (Cdb_valid),
            .cdb_tag   (Cdb_tag),
            .cdb_value (Cdb_value),
            .is_free   (free_m[g]),
            .is_ready  (ready_m[g]),
            .is_exec   (exec_m[g]),
            .op        (e_op[g]),
            .rd        (e_rd[g]),
            .vj        (e_vj[g]),
            .vk        (e_vk[g])
        );
    end

    // Allocation and dispatch both favour the lowest index; Done matches at most one EXEC entry.
    always_comb begin
        alloc_v     = '0;
        disp_v      = '0;
        comp_v      = '0;
        alloc_found = 1'b0;
        disp_found  = 1'b0;
        Issue_tag   = '0;
        Exec_op     = '0;
        Exec_vj     = '0;
        Exec_vk     = '0;
        Exec_tag    = '0;
        done_rd     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (free_m[i] && !alloc_found) begin
                alloc_found = 1'b1;
                Issue_tag   = tag_of[i];
                alloc_v[i]  = Issue_valid;
            end
            if (ready_m[i] && !disp_found) begin
                disp_found = 1'b1;
                Exec_op    = e_op[i];
                Exec_vj    = e_vj[i];
                Exec_vk    = e_vk[i];
                Exec_tag   = tag_of[i];
                disp_v[i]  = Exec_ready;
            end
            if (exec_m[i] && Done && (Done_tag == tag_of[i])) begin
                comp_v[i] = 1'b1;
                done_rd   = e_rd[i];
            end
        end
    end

    assign Issue_ready = |free_m;
    assign Exec_valid  = |ready_m;
    assign Busy        = ~free_m;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            R_enable <= 1'b0;
            R_target <= '0;
        end else begin
            R_enable <= |comp_v;
            if (|comp_v) R_target <= done_rd;
        end
    end

endmodule

// File: doc/res_station_bank.md
Name: res_station_bank

Overview:
- Parametrised reservation-station bank for the Tomasulo datapath. Holds DEPTH entries that share one functional unit.
- Accepts instructions from the issue stage and snoops the common data bus (CDB) for missing operands.
- Dispatches operand-complete entries to the FU over a valid/ready handshake, then frees the entry and pulses a register-file write enable when the FU signals completion.
- Replaces the single-entry, level-sensitive station with a clocked, multi-entry, CDB-aware one.

Parameters:
- DATA_W, 16, operand/result width
- TAG_W, 3, producer tag width; tag 0 means "value present"
- OP_W, 3, opcode width
- REG_W, 3, architectural register index width
- DEPTH, 2, number of entries (1..2**TAG_W-1)
- TAG_BASE, 1, tag of entry 0; entry i has tag TAG_BASE+i; TAG_BASE>=1 and TAG_BASE+DEPTH-1 <= 2**TAG_W-1

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Issue_valid  in  1  issue stage presents an instruction
- Issue_ready  out  1  at least one entry FREE (combinational from state)
- Issue_op  in  OP_W  opcode
- Issue_rd  in  REG_W  destination register
- Vj, Vk  in  DATA_W  operand values (valid when matching Q is 0)
- Qj, Qk  in  TAG_W  producer tags; 0 = ready
- Issue_tag  out  TAG_W  tag the accepting entry will take (valid when Issue_ready)
- Cdb_valid  in  1  CDB broadcast this cycle
- Cdb_tag  in  TAG_W  broadcasting producer
- Cdb_value  in  DATA_W  broadcast result
- Exec_valid  out  1  an entry is READY
- Exec_ready  in  1  FU accepts
- Exec_op  out  OP_W  selected entry opcode
- Exec_vj, Exec_vk  out  DATA_W  selected entry operands
- Exec_tag  out  TAG_W  selected entry tag
- Done  in  1  FU finished an operation
- Done_tag  in  TAG_W  tag of the finished operation
- R_enable  out  1  one-cycle register-file write enable
- R_target  out  REG_W  destination register for R_enable
- Busy  out  DEPTH  per-entry "not FREE" mask

Behaviour:
- Per-entry state: FREE, WAIT (a Q is nonzero), READY (both Q are 0), EXEC (handed to the FU). Each entry holds op, rd, Vj, Vk, Qj, Qk.
- Reset (synchronous): all entries go to FREE, Q fields are cleared, R_enable=0, R_target=0. Therefore Busy=0, Exec_valid=0 and Issue_ready=1 on the following cycle. Reset overrides every other event in the same cycle, including mid-EXEC; any later Done for a discarded tag is ignored.
- Allocation: on Issue_valid && Issue_ready, the lowest-index FREE entry loads the instruction. Issue_tag is that entry's tag. Issue_valid while not ready is dropped; the issue stage must hold.
- Issue/CDB bypass: if Cdb_valid and Cdb_tag equals a nonzero issued Qj (or Qk) in the same cycle, latch Cdb_value with Q=0.
- Next state after allocation: READY if both Q are 0 after bypass, else WAIT.
- Snooping: each cycle, every WAIT/READY entry with Qx==Cdb_tag (Qx!=0) under Cdb_valid latches Cdb_value into Vx and sets Qx=0. Both operands may resolve in the same cycle. The transition WAIT->READY occurs at that edge.
- Dispatch selection: Exec_valid and Exec_* reflect the lowest-index READY entry, combinationally from registered state. Data is therefore visible one cycle after the operand resolves; no same-cycle CDB forwarding to the FU.
- Dispatch: on Exec_valid && Exec_ready, the selected entry goes READY->EXEC.
- Completion: on Done with Done_tag matching an EXEC entry, that entry goes to FREE. On the next edge R_enable=1 and R_target=the entry's rd, for exactly one cycle.
- Done with no matching EXEC entry (tag outside the bank, tag 0, or entry not in EXEC) has no effect and R_enable stays 0.
- Simultaneous events:
  - Done plus issue in the same cycle: the freed entry is not allocatable until the next cycle, because Issue_ready uses current state.
  - Dispatch plus Done on different entries: both take effect.
  - A CDB snoop of the bank's own tag is allowed (a dependent entry in the same bank).
- Full: all entries non-FREE gives Issue_ready=0. Empty: Busy=0 and Exec_valid=0.

Decomposition:
- Package rs_pkg: entry-state enum (FREE/WAIT/READY/EXEC), localparam TAG_NONE=0, and an entry struct typedef built from the width parameters.
- Sub-module rs_entry: one entry's state register, capture logic and CDB snoop. It is instantiated DEPTH times.
- The top level holds allocation and dispatch priority encoders, Done matching and the R_enable register.

Test Plan:
- Reset, then issue op=1 rd=3 Vj=5 Vk=7 Qj=Qk=0 -> Issue_tag=1. Next cycle Exec_valid=1, Exec_vj=5, Exec_vk=7, Exec_tag=1. Exec_ready=1, then Done tag 1 -> R_enable=1, R_target=3 for one cycle, Busy=0.
- Issue with Qj=4 -> Exec_valid stays 0. Cdb_valid with tag 4, value 0x00AA -> Exec_valid=1 next cycle with Exec_vj=0x00AA.
- Issue with Qk=5 while Cdb broadcasts tag 5, value 9 in the same cycle -> entry is READY next cycle with Exec_vk=9.
- DEPTH=2: two issues -> Issue_ready=0 and a third Issue_valid is dropped. Done for tag 1 plus Issue_valid in the same cycle -> not accepted. Accepted the following cycle with Issue_tag=1.
- Two READY entries -> entry 0 dispatched first. Exec_ready held low -> Exec_* stable and no state change.
- Assert Reset while an entry is in EXEC, then Done tag 1 -> Busy=0 and R_enable stays 0.
